// File: rtl/evt_time_sync_arbiter_pkg.sv
// Event stream types and arbiter FSM encoding shared by the time-synchronising
// arbiter, its round-robin helper and the stream interface.
package evt_time_sync_arbiter_pkg;

   localparam int EVT_ARB_MAX_IN = 16;
   localparam int TIME_W         = 16;

   typedef logic [TIME_W-1:0] timestamp_t;

   typedef enum logic [1:0] {
      EVT_SPIKE  = 2'd0,
      EVT_UPDATE = 2'd1,
      EVT_SYNC   = 2'd2,
      EVT_TIME   = 2'd3
   } evt_op_t;

   // For EVT_TIME the value is the timestamp; for other ops it is payload.
   typedef struct packed {
      evt_op_t    op;
      timestamp_t value;
   } sne_event_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DRAIN     = 2'd1,
      EMIT_TIME = 2'd2
   } evt_arb_state_t;

   function automatic sne_event_t time_event(timestamp_t t);
      sne_event_t e;
      e.op    = EVT_TIME;
      e.value = t;
      return e;
   endfunction

endpackage

// File: rtl/evt_time_sync_arbiter_if.sv
// One SNE event stream: the src side drives evt/valid, the dst side drives ready.
// A transfer happens on a cycle where valid and ready are both high; once valid
// is raised, evt stays stable and valid stays high until that transfer.
interface evt_time_sync_arbiter_if;
   import evt_time_sync_arbiter_pkg::*;

   sne_event_t evt;
   logic       valid;
   logic       ready;

   modport src (output evt, output valid, input ready);
   modport dst (input evt, input valid, output ready);

endinterface

// File: rtl/evt_time_sync_arbiter_rr_grant.sv
// Combinational round-robin priority encoder: first request at or after ptr_i,
// wrapping modulo N_IN. The pointer register lives in the parent.
module evt_time_sync_arbiter_rr_grant #(
   parameter  int N_IN  = 4,
   localparam int SEL_W = $clog2(N_IN)
) (
   input  logic [N_IN-1:0]  req_i,
   input  logic [SEL_W-1:0] ptr_i,
   output logic [SEL_W-1:0] gnt_idx_o,
   output logic             gnt_valid_o
);

   int               idx;
   logic [SEL_W-1:0] idx_s;

   always_comb begin
      gnt_idx_o   = '0;
      gnt_valid_o = 1'b0;
      idx         = 0;
      idx_s       = '0;
      for (int k = 0; k < N_IN; k++) begin
         idx   = (int'(ptr_i) + k) % N_IN;
         idx_s = SEL_W'(idx);
         if (!gnt_valid_o && req_i[idx_s]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = idx_s;
         end
      end
   end

endmodule

// File: rtl/evt_time_sync_arbiter.sv
// Merges N_IN event streams into one time-ordered stream: data is forwarded
// round-robin within a time step, and one EVT_TIME marker is emitted per step.
module evt_time_sync_arbiter
   import evt_time_sync_arbiter_pkg::*;
#(
   parameter  int N_IN  = 4,
   localparam int SEL_W = $clog2(N_IN)
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        enable_i,
   input  logic                        clear_i,
   input  logic [N_IN-1:0]             in_mask_i,
   evt_time_sync_arbiter_if.dst        evt_in_dst [N_IN],
   evt_time_sync_arbiter_if.src        evt_out_src,
   output timestamp_t                  curr_time_o,
   output logic                        busy_o,
   output evt_arb_state_t              dbg_state_o
);

   evt_arb_state_t   state_q, state_d;
   timestamp_t       curr_time_q, curr_time_d;
   timestamp_t       next_time_q, next_time_d;
   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [SEL_W-1:0] lock_idx_q, lock_idx_d;
   logic             grant_lock_q, grant_lock_d;

   sne_event_t       in_evt [N_IN];
   logic [N_IN-1:0]  in_valid;
   logic [N_IN-1:0]  in_ready;
   logic [N_IN-1:0]  is_time;
   logic [N_IN-1:0]  head_future;
   logic [N_IN-1:0]  head_stale;
   logic [N_IN-1:0]  head_data;

   sne_event_t       out_evt;
   logic             out_valid;

   for (genvar g = 0; g < N_IN; g++) begin : g_in
      assign in_evt[g]             = evt_in_dst[g].evt;
      assign in_valid[g]           = evt_in_dst[g].valid;
      assign evt_in_dst[g].ready   = in_ready[g];
      assign is_time[g]            = (in_evt[g].op == EVT_TIME);
      assign head_future[g] = in_mask_i[g] & in_valid[g] & is_time[g]
                              & (in_evt[g].value > curr_time_q);
      assign head_stale[g]  = in_mask_i[g] & in_valid[g] & is_time[g]
                              & (in_evt[g].value <= curr_time_q);
      assign head_data[g]   = in_mask_i[g] & in_valid[g] & ~is_time[g];
   end

   logic [SEL_W-1:0] gnt_idx;
   logic             gnt_valid;

   evt_time_sync_arbiter_rr_grant #(.N_IN(N_IN)) u_rr_grant (
      .req_i       (head_data),
      .ptr_i       (rr_ptr_q),
      .gnt_idx_o   (gnt_idx),
      .gnt_valid_o (gnt_valid)
   );

   // A locked grant keeps presenting the same input until it is accepted,
   // even while enable_i is low.
   logic [SEL_W-1:0] sel_idx;
   logic             sel_valid;
   assign sel_idx   = grant_lock_q ? lock_idx_q : gnt_idx;
   assign sel_valid = grant_lock_q | (enable_i & gnt_valid);

   logic all_future;
   assign all_future = (in_mask_i != '0) && ((in_mask_i & ~head_future) == '0);

   timestamp_t min_time;
   always_comb begin
      min_time = '1;
      for (int i = 0; i < N_IN; i++) begin
         if (head_future[i] && (in_evt[i].value < min_time)) begin
            min_time = in_evt[i].value;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      curr_time_d  = curr_time_q;
      next_time_d  = next_time_q;
      rr_ptr_d     = rr_ptr_q;
      lock_idx_d   = lock_idx_q;
      grant_lock_d = grant_lock_q;
      out_valid    = 1'b0;
      out_evt      = '0;
      in_ready     = '0;

      unique case (state_q)
         IDLE: begin
            if (enable_i && (in_mask_i != '0)) state_d = DRAIN;
         end

         DRAIN: begin
            if (enable_i) in_ready = head_stale;
            if (sel_valid) begin
               out_valid         = 1'b1;
               out_evt           = in_evt[sel_idx];
               in_ready[sel_idx] = evt_out_src.ready;
               if (evt_out_src.ready) begin
                  grant_lock_d = 1'b0;
                  rr_ptr_d     = (sel_idx == SEL_W'(N_IN - 1)) ? '0 : sel_idx + 1'b1;
               end else begin
                  grant_lock_d = 1'b1;
                  lock_idx_d   = sel_idx;
               end
            end else if (in_mask_i == '0) begin
               state_d = IDLE;
            end else if (enable_i && all_future) begin
               next_time_d = min_time;
               state_d     = EMIT_TIME;
            end
         end

         EMIT_TIME: begin
            // Once presented, the marker is held until accepted.
            if (enable_i || grant_lock_q) begin
               out_valid = 1'b1;
               out_evt   = time_event(next_time_q);
               if (evt_out_src.ready) begin
                  grant_lock_d = 1'b0;
                  curr_time_d  = next_time_q;
                  state_d      = DRAIN;
               end else begin
                  grant_lock_d = 1'b1;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         curr_time_q  <= '0;
         next_time_q  <= '0;
         rr_ptr_q     <= '0;
         lock_idx_q   <= '0;
         grant_lock_q <= 1'b0;
      end else if (clear_i) begin
         state_q      <= IDLE;
         curr_time_q  <= '0;
         next_time_q  <= '0;
         rr_ptr_q     <= '0;
         lock_idx_q   <= '0;
         grant_lock_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         curr_time_q  <= curr_time_d;
         next_time_q  <= next_time_d;
         rr_ptr_q     <= rr_ptr_d;
         lock_idx_q   <= lock_idx_d;
         grant_lock_q <= grant_lock_d;
      end
   end

   assign evt_out_src.valid = out_valid;
   assign evt_out_src.evt   = out_evt;
   assign curr_time_o       = curr_time_q;
   assign busy_o            = (state_q != IDLE);
   assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_evt_time_sync_arbiter.sv
// Bench for evt_time_sync_arbiter: directed scenarios plus randomized streams
// checked against an epoch-level model of the merge.
module tb_evt_time_sync_arbiter;
   import evt_time_sync_arbiter_pkg::*;

   localparam int         N     = 4;
   localparam timestamp_t END_T = 16'd100;

   logic           clk, rst_n, enable, clear;
   logic [N-1:0]   mask;
   timestamp_t     curr_time;
   logic           busy;
   evt_arb_state_t dbg_state;

   logic           in_valid [N];
   sne_event_t     in_evt   [N];
   logic           in_ready [N];
   logic           out_ready, out_valid;
   sne_event_t     out_evt;
   logic           rand_ready, rand_enable;

   sne_event_t     src_q [N][$];
   sne_event_t     obs_q [$];
   timestamp_t     exp_q [$];
   logic [31:0]    exp_src_q [N][$];

   int n_checks = 0;
   int n_errors = 0;

   evt_time_sync_arbiter_if evt_in [N] ();
   evt_time_sync_arbiter_if evt_out ();

   for (genvar g = 0; g < N; g++) begin : g_conn
      assign evt_in[g].valid = in_valid[g];
      assign evt_in[g].evt   = in_evt[g];
      assign in_ready[g]     = evt_in[g].ready;
   end
   assign evt_out.ready = out_ready;
   assign out_valid     = evt_out.valid;
   assign out_evt       = evt_out.evt;

   evt_time_sync_arbiter #(.N_IN(N)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .enable_i    (enable),
      .clear_i     (clear),
      .in_mask_i   (mask),
      .evt_in_dst  (evt_in),
      .evt_out_src (evt_out),
      .curr_time_o (curr_time),
      .busy_o      (busy),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver ----------------
   function automatic sne_event_t mk_data(int src, int seq);
      sne_event_t e;
      e.op    = EVT_SPIKE;
      e.value = {4'(src), 12'(seq)};
      return e;
   endfunction

   function automatic sne_event_t mk_time(int t);
      sne_event_t e;
      e.op    = EVT_TIME;
      e.value = 16'(t);
      return e;
   endfunction

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         in_valid[i] = (src_q[i].size() > 0);
         in_evt[i]   = '0;
         if (src_q[i].size() > 0) in_evt[i] = src_q[i][0];
      end
   endtask

   // Handshakes are sampled at negedge; inputs change 1 time unit after posedge.
   task automatic cycle();
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (in_valid[i] && in_ready[i]) void'(src_q[i].pop_front());
      end
      if (out_valid && out_ready) obs_q.push_back(out_evt);
      @(posedge clk);
      #1;
      if (rand_ready)  out_ready = ($urandom_range(0, 3) != 0);
      if (rand_enable) enable    = ($urandom_range(0, 7) != 0);
      drive_inputs();
   endtask

   task automatic flush();
      for (int i = 0; i < N; i++) src_q[i].delete();
      obs_q.delete();
      drive_inputs();
   endtask

   task automatic start_test(input logic [N-1:0] m);
      flush();
      rand_ready  = 1'b0;
      rand_enable = 1'b0;
      enable      = 1'b1;
      out_ready   = 1'b1;
      clear       = 1'b1;
      cycle();
      clear = 1'b0;
      mask  = m;
   endtask

   function automatic bit queues_empty();
      for (int i = 0; i < N; i++) begin
         if (mask[i] && (src_q[i].size() != 0)) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic run_until_done(input int budget, input string name);
      int k;
      k = 0;
      while (!queues_empty() && (k < budget)) begin
         cycle();
         k++;
      end
      n_checks++;
      if (!queues_empty()) begin
         n_errors++;
         $display("FAIL %s_drain: inputs still pending after %0d cycles (required empty)", name, budget);
      end
   endtask

   // ---------------- reference model ----------------
   // Each input drains data until its next marker later than global time t;
   // the next emitted time is the smallest such marker. Data is tagged with
   // the number of markers emitted before it.
   task automatic build_model();
      sne_event_t m_q [N][$];
      int         t, ep, nxt;
      bit         any;
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
         m_q[i] = src_q[i];
         exp_src_q[i].delete();
      end
      t   = 0;
      ep  = 0;
      any = 1'b1;
      while (any) begin
         any = 1'b0;
         nxt = 1 << 20;
         for (int i = 0; i < N; i++) begin
            while ((m_q[i].size() > 0) &&
                   ((m_q[i][0].op != EVT_TIME) || (int'(m_q[i][0].value) <= t))) begin
               if (m_q[i][0].op != EVT_TIME) exp_src_q[i].push_back({16'(ep), m_q[i][0].value});
               void'(m_q[i].pop_front());
            end
            if (m_q[i].size() > 0) begin
               any = 1'b1;
               if (int'(m_q[i][0].value) < nxt) nxt = int'(m_q[i][0].value);
            end
         end
         if (any) begin
            exp_q.push_back(16'(nxt));
            t = nxt;
            ep++;
         end
      end
   endtask

   task automatic gen_streams();
      int cur, seq, n;
      seq = 1;
      for (int i = 0; i < N; i++) begin
         cur = 0;
         n   = int'($urandom_range(1, 5));
         for (int s = 0; s < n; s++) begin
            repeat ($urandom_range(0, 2)) begin
               src_q[i].push_back(mk_data(i, seq));
               seq++;
            end
            if ($urandom_range(0, 3) == 0) src_q[i].push_back(mk_time(int'($urandom_range(0, cur))));
            cur += int'($urandom_range(1, 5));
            src_q[i].push_back(mk_time(cur));
         end
         repeat ($urandom_range(0, 2)) begin
            src_q[i].push_back(mk_data(i, seq));
            seq++;
         end
         src_q[i].push_back(mk_time(int'(END_T)));
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b1; enable = 1'b1; clear = 1'b0; mask = '1;
      out_ready = 1'b1; rand_ready = 1'b0; rand_enable = 1'b0;
      for (int i = 0; i < N; i++) src_q[i].push_back(mk_data(i, 1));
      drive_inputs();
      #1 rst_n = 1'b0;
      #2;
      for (int pass = 0; pass < 2; pass++) begin
         n_checks++;
         if (out_valid !== 1'b0 || out_evt !== '0) begin
            n_errors++;
            $display("FAIL reset_out: valid=%b evt=%h (required 0/0)", out_valid, out_evt);
         end
         n_checks++;
         if ({in_ready[3], in_ready[2], in_ready[1], in_ready[0]} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_ready: ready=%b%b%b%b (required 0000)",
                     in_ready[3], in_ready[2], in_ready[1], in_ready[0]);
         end
         n_checks++;
         if (busy !== 1'b0 || curr_time !== '0 || dbg_state !== IDLE) begin
            n_errors++;
            $display("FAIL reset_state: busy=%b time=%0d state=%0d (required 0/0/IDLE)",
                     busy, curr_time, dbg_state);
         end
         @(posedge clk);
         #1;
      end
      flush();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_rr_order();
      sne_event_t exp_seq [$];
      sne_event_t got;
      start_test(4'b0011);
      src_q[0].push_back(mk_data(0, 1));
      src_q[0].push_back(mk_data(0, 2));
      src_q[0].push_back(mk_time(1));
      src_q[1].push_back(mk_data(1, 1));
      src_q[1].push_back(mk_time(1));
      drive_inputs();
      run_until_done(40, "rr_order");
      exp_seq.push_back(mk_data(0, 1));
      exp_seq.push_back(mk_data(1, 1));
      exp_seq.push_back(mk_data(0, 2));
      exp_seq.push_back(mk_time(1));
      n_checks++;
      if (obs_q.size() != exp_seq.size()) begin
         n_errors++;
         $display("FAIL rr_order_len: got %0d events, expected %0d", obs_q.size(), exp_seq.size());
      end
      for (int k = 0; k < exp_seq.size(); k++) begin
         got = (k < obs_q.size()) ? obs_q[k] : '0;
         n_checks++;
         if (got !== exp_seq[k]) begin
            n_errors++;
            $display("FAIL rr_order[%0d]: got %h, expected %h", k, got, exp_seq[k]);
         end
      end
      n_checks++;
      if (curr_time !== 16'd1) begin
         n_errors++;
         $display("FAIL rr_order_time: got %0d, expected 1", curr_time);
      end
   endtask

   task automatic test_skip_time();
      sne_event_t exp_seq [$];
      sne_event_t got;
      start_test(4'b0011);
      src_q[0].push_back(mk_time(5));
      src_q[1].push_back(mk_time(3));
      src_q[1].push_back(mk_data(1, 7));
      src_q[1].push_back(mk_time(5));
      drive_inputs();
      run_until_done(40, "skip_time");
      exp_seq.push_back(mk_time(3));
      exp_seq.push_back(mk_data(1, 7));
      exp_seq.push_back(mk_time(5));
      n_checks++;
      if (obs_q.size() != exp_seq.size()) begin
         n_errors++;
         $display("FAIL skip_time_len: got %0d events, expected %0d", obs_q.size(), exp_seq.size());
      end
      for (int k = 0; k < exp_seq.size(); k++) begin
         got = (k < obs_q.size()) ? obs_q[k] : '0;
         n_checks++;
         if (got !== exp_seq[k]) begin
            n_errors++;
            $display("FAIL skip_time[%0d]: got %h, expected %h", k, got, exp_seq[k]);
         end
      end
      n_checks++;
      if (curr_time !== 16'd5) begin
         n_errors++;
         $display("FAIL skip_time_time: got %0d, expected 5", curr_time);
      end
   endtask

   task automatic test_backpressure();
      sne_event_t exp_seq [$];
      sne_event_t got;
      start_test(4'b0011);
      out_ready = 1'b0;
      src_q[0].push_back(mk_data(0, 1));
      src_q[0].push_back(mk_data(0, 2));
      src_q[1].push_back(mk_data(1, 1));
      drive_inputs();
      cycle();
      for (int k = 0; k < 4; k++) begin
         if (k == 2) begin
            enable = 1'b0;
            #1;
         end
         n_checks++;
         if (out_valid !== 1'b1 || out_evt !== mk_data(0, 1) ||
             in_ready[0] !== 1'b0 || in_ready[1] !== 1'b0) begin
            n_errors++;
            $display("FAIL backpressure_hold[%0d]: valid=%b evt=%h rdy=%b%b (required 1/%h/00)",
                     k, out_valid, out_evt, in_ready[1], in_ready[0], mk_data(0, 1));
         end
         cycle();
      end
      enable    = 1'b1;
      out_ready = 1'b1;
      run_until_done(20, "backpressure");
      exp_seq.push_back(mk_data(0, 1));
      exp_seq.push_back(mk_data(1, 1));
      exp_seq.push_back(mk_data(0, 2));
      n_checks++;
      if (obs_q.size() != exp_seq.size()) begin
         n_errors++;
         $display("FAIL backpressure_len: got %0d events, expected %0d", obs_q.size(), exp_seq.size());
      end
      for (int k = 0; k < exp_seq.size(); k++) begin
         got = (k < obs_q.size()) ? obs_q[k] : '0;
         n_checks++;
         if (got !== exp_seq[k]) begin
            n_errors++;
            $display("FAIL backpressure[%0d]: got %h, expected %h", k, got, exp_seq[k]);
         end
      end
   endtask

   task automatic test_mask();
      start_test(4'b0001);
      src_q[0].push_back(mk_data(0, 3));
      src_q[0].push_back(mk_time(2));
      src_q[1].push_back(mk_data(1, 9));
      drive_inputs();
      run_until_done(30, "mask");
      n_checks++;
      if (obs_q.size() != 2 || obs_q[0] !== mk_data(0, 3) || obs_q[1] !== mk_time(2)) begin
         n_errors++;
         $display("FAIL mask_seq: got %0d events first=%h (required %h then %h)",
                  obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, mk_data(0, 3), mk_time(2));
      end
      n_checks++;
      if (src_q[1].size() != 1 || in_ready[1] !== 1'b0) begin
         n_errors++;
         $display("FAIL mask_ignored: in1 pending=%0d ready=%b (required 1/0)", src_q[1].size(), in_ready[1]);
      end
      n_checks++;
      if (curr_time !== 16'd2) begin
         n_errors++;
         $display("FAIL mask_time: got %0d, expected 2", curr_time);
      end
   endtask

   task automatic test_stale();
      start_test(4'b0001);
      src_q[0].push_back(mk_time(4));
      src_q[0].push_back(mk_time(3));
      src_q[0].push_back(mk_time(4));
      drive_inputs();
      run_until_done(30, "stale");
      n_checks++;
      if (obs_q.size() != 1 || obs_q[0] !== mk_time(4)) begin
         n_errors++;
         $display("FAIL stale_seq: got %0d events first=%h (required one %h)",
                  obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, mk_time(4));
      end
      n_checks++;
      if (curr_time !== 16'd4 || busy !== 1'b1 || dbg_state !== DRAIN) begin
         n_errors++;
         $display("FAIL stale_state: time=%0d busy=%b state=%0d (required 4/1/DRAIN)",
                  curr_time, busy, dbg_state);
      end
   endtask

   task automatic test_clear_reset();
      start_test(4'b0001);
      src_q[0].push_back(mk_time(7));
      drive_inputs();
      run_until_done(20, "clear_setup");
      n_checks++;
      if (curr_time !== 16'd7) begin
         n_errors++;
         $display("FAIL clear_setup_time: got %0d, expected 7", curr_time);
      end
      out_ready = 1'b0;
      src_q[0].push_back(mk_data(0, 5));
      drive_inputs();
      cycle();
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || curr_time !== '0 || out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL clear_state: busy=%b time=%0d valid=%b (required 0/0/0)", busy, curr_time, out_valid);
      end
      flush();
      src_q[0].push_back(mk_time(9));
      drive_inputs();
      cycle();
      cycle();
      n_checks++;
      if (out_valid !== 1'b1 || out_evt !== mk_time(9) || dbg_state !== EMIT_TIME) begin
         n_errors++;
         $display("FAIL emit_present: valid=%b evt=%h state=%0d (required 1/%h/EMIT_TIME)",
                  out_valid, out_evt, dbg_state, mk_time(9));
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_evt !== '0 || busy !== 1'b0 || curr_time !== '0 || in_ready[0] !== 1'b0) begin
         n_errors++;
         $display("FAIL async_reset: valid=%b evt=%h busy=%b time=%0d rdy0=%b (required all 0)",
                  out_valid, out_evt, busy, curr_time, in_ready[0]);
      end
      flush();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      int ep, s;
      for (int round = 0; round < 8; round++) begin
         start_test('1);
         gen_streams();
         build_model();
         drive_inputs();
         rand_ready  = 1'b1;
         rand_enable = 1'b1;
         run_until_done(3000, "random");
         rand_ready  = 1'b0;
         rand_enable = 1'b0;
         enable      = 1'b1;
         ep = 0;
         foreach (obs_q[k]) begin
            n_checks++;
            if (obs_q[k].op == EVT_TIME) begin
               if (ep >= exp_q.size() || obs_q[k].value !== exp_q[ep]) begin
                  n_errors++;
                  $display("FAIL random_time[%0d]: got %0d, expected %0d", ep, obs_q[k].value,
                           (ep < exp_q.size()) ? exp_q[ep] : 16'hffff);
               end
               ep++;
            end else begin
               s = int'(obs_q[k].value[15:12]);
               if (s >= N || exp_src_q[s].size() == 0) begin
                  n_errors++;
                  $display("FAIL random_data: got unexpected %h in step %0d", obs_q[k], ep);
               end else if (exp_src_q[s].pop_front() !== {16'(ep), obs_q[k].value}) begin
                  n_errors++;
                  $display("FAIL random_data: got %h in step %0d, not next expected for input %0d",
                           obs_q[k].value, ep, s);
               end
            end
         end
         n_checks++;
         if (ep != exp_q.size() || curr_time !== END_T) begin
            n_errors++;
            $display("FAIL random_steps: got %0d markers time=%0d, expected %0d markers time=%0d",
                     ep, curr_time, exp_q.size(), END_T);
         end
         for (int i = 0; i < N; i++) begin
            n_checks++;
            if (exp_src_q[i].size() != 0) begin
               n_errors++;
               $display("FAIL random_missing: input %0d has %0d events not forwarded (required 0)",
                        i, exp_src_q[i].size());
            end
         end
      end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      test_reset();
      test_rr_order();
      test_skip_time();
      test_backpressure();
      test_mask();
      test_stale();
      test_clear_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/evt_time_sync_arbiter.md
Name: evt_time_sync_arbiter

Overview:
Merges N_IN SNE event streams into one time-ordered output stream for the engine.
- Within a time step it forwards non-time events from all inputs round-robin.
- It advances global time only when every active input has reached a future EVT_TIME marker, then emits exactly one EVT_TIME event per step.
- It sits between the per-source streamers and the time-gap filler in front of the engine, and owns the global current-time register.

Parameters:
N_IN, 4, number of input event streams (2..16)
SEL_W, $clog2(N_IN), width of grant index (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
enable_i  in  1  arbitration enable; low freezes all handshakes
clear_i  in  1  synchronous soft reset of time/state
in_mask_i  in  N_IN  1 = input participates in time synchronisation
evt_in_dst[N_IN]  SNE_EVENT_STREAM.dst  -  input streams (evt, valid, ready)
evt_out_src  SNE_EVENT_STREAM.src  -  merged output stream
curr_time_o  out  timestamp_t value width  last emitted global time
busy_o  out  1  high when state != IDLE

Behaviour:
Reset (rst_ni low): state=IDLE, curr_time_q=0, rr_ptr_q=0, grant_lock_q=0.
- Outputs at reset: out valid=0, out evt=0, all in ready=0, busy_o=0, curr_time_o=0.

Per-input classification (combinational, masked inputs always ignored):
- head_future[i] = valid & op==EVT_TIME & value>curr_time_q.
- head_stale[i] = valid & op==EVT_TIME & value<=curr_time_q.
- head_data[i] = valid & op!=EVT_TIME.

States:
- IDLE: when enable_i=1 and in_mask_i!=0, go to DRAIN next cycle.
- DRAIN:
  - Stale heads are absorbed: ready=1, no output. All stale inputs are absorbed in parallel in one cycle.
  - Among head_data inputs, a round-robin grant starting at rr_ptr_q selects one. It is forwarded combinationally (zero latency): out.evt=in.evt, out.valid=1, in.ready=out.ready.
  - On handshake, rr_ptr_q=grant+1 mod N_IN.
  - If out.valid=1 and out.ready=0, the grant is locked (grant_lock_q) until the handshake. Output data stays stable and no re-arbitration happens.
  - When every masked-in input is head_future and no transfer is pending, latch next_time_q = minimum value over those inputs (unsigned; ties to the lowest index irrelevant) and go to EMIT_TIME.
- EMIT_TIME:
  - Drive out.evt = {EVT_TIME, next_time_q}, out.valid=1; all in ready=0.
  - On out.ready: curr_time_q=next_time_q, then go to DRAIN. Matching heads become stale and are absorbed in the following cycle.

Timing and ordering:
- Time advance costs 2 cycles minimum (emit + absorb).
- Time is strictly monotonic. There is no wrap-around handling: value at max stays put, and further equal markers are absorbed.
- A marker with value 0 after reset is stale and absorbed; time 0 is never emitted.

Control conditions:
- enable_i=0: all in ready=0 and out valid=0 except a locked pending output, which is held until accepted. State and counters are held.
- clear_i=1 (priority over enable_i): next cycle state=IDLE, curr_time_q=0, rr_ptr_q=0, lock cleared. Any pending output is dropped; the caller clears only when downstream is idle.
- in_mask_i changes take effect immediately. An input dropped mid-DRAIN no longer blocks time advance. in_mask_i=0 in DRAIN returns to IDLE.
- Simultaneous data and future heads: data is always drained before time advances.

Decomposition:
Shared package (sne_evt_stream_pkg) additions:
- typedef evt_arb_state_t (IDLE, DRAIN, EMIT_TIME).
- constant EVT_ARB_MAX_IN=16.

Sub-module evt_rr_grant:
- Parametric round-robin priority encoder: req[N_IN], ptr -> gnt_idx, gnt_valid.
- Purely combinational; the pointer register lives in the parent.
- The min-finder stays inline.

Test Plan:
1. N_IN=2, in0: D(a), D(b), T(1); in1: D(c), T(1) -> output a,c,b,T(1) in that order; curr_time_o=1; both T(1) absorbed.
2. in0: T(5); in1: T(3), D(x), T(5) -> output T(3), x, T(5); no T(4) emitted; curr_time_o=5.
3. Backpressure: hold out.ready=0 for 4 cycles with in0,in1 both data-valid -> output evt/valid stable; grant unchanged until accept; ptr then advances.
4. in_mask_i=2'b01, in1 silent, in0: D(a), T(2) -> output a, T(2); in1 never blocks.
5. Stale markers: after curr_time=4, in0 presents T(3) then T(4) -> both absorbed, none output, no state change.
6. Assert clear_i mid-DRAIN with curr_time=7 -> next cycle busy_o=0, curr_time_o=0; rst_ni pulse mid-EMIT_TIME -> all outputs at reset values asynchronously.
